// File: rtl/fire_dec_ctrl_pkg.sv
// Shared definitions for the Fire-code decode sequencer.
//   R     : syndrome register width, fixed by the generator polynomial
//   CW    : width of the shift counters and of the syndrome register's count port
//   state_t : sequencer states
package fire_dec_ctrl_pkg;

    localparam int R  = 9;
    localparam int CW = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        TRAP  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/fire_dec_ctrl_if.sv
// Bundle of the signals around the Fire-code decode sequencer.
//   Upstream side  : start, codeword_in -> ready, done and the result outputs
//   Syndrome side  : p_clr, p_shift, p_data -> p_count, p_syndrome
// The slave modport is the sequencer; the master modport is everything
// around it (receive buffer, correction stage and the syndrome register).
interface fire_dec_ctrl_if #(
    parameter int N = 64,
    parameter int B = 4
);
    import fire_dec_ctrl_pkg::*;

    logic          start;
    logic [N-1:0]  codeword_in;
    logic          ready;
    logic          done;
    logic          err_detected;
    logic          err_correctable;
    logic [B-1:0]  burst_pat;
    logic [CW-1:0] trap_shifts;
    logic          count_err;
    logic          p_clr;
    logic          p_shift;
    logic [N-1:0]  p_data;
    logic [CW-1:0] p_count;
    logic [R-1:0]  p_syndrome;

    modport slave (
        input  start, codeword_in, p_count, p_syndrome,
        output ready, done, err_detected, err_correctable, burst_pat,
               trap_shifts, count_err, p_clr, p_shift, p_data
    );

    modport master (
        output start, codeword_in, p_count, p_syndrome,
        input  ready, done, err_detected, err_correctable, burst_pat,
               trap_shifts, count_err, p_clr, p_shift, p_data
    );

endinterface

// File: rtl/fire_dec_ctrl.sv
// Fire-code decode sequencer.
// Latches a codeword, clears the external syndrome register, clocks N
// codeword bits through it, classifies the syndrome and, if non-zero,
// keeps shifting (the register zero-fills past N) until the burst lands in
// the low B syndrome bits or N trap shifts have been spent.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fire_dec_ctrl_if.slave (handshake, results, syndrome register link)
module fire_dec_ctrl
    import fire_dec_ctrl_pkg::*;
#(
    parameter int N = 64,
    parameter int B = 4
) (
    input  logic            clk,
    input  logic            rst,
    fire_dec_ctrl_if.slave  bus
);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] tcnt_reg;
    logic [N-1:0]  p_data_reg;
    logic          p_clr_reg;
    logic          err_det_reg;
    logic          err_corr_reg;
    logic          count_err_reg;
    logic [B-1:0]  burst_reg;
    logic [CW-1:0] trap_shifts_reg;

    logic trapped;
    logic trap_exhausted;
    logic shift_last;
    logic syn_zero;
    logic ready_c;
    logic done_c;
    logic p_shift_c;

    // A burst is trapped once everything above the low B bits is clear,
    // provided something is left in the low bits.
    assign syn_zero       = (bus.p_syndrome == '0);
    assign trapped        = (bus.p_syndrome[R-1:B] == '0) && !syn_zero;
    assign trap_exhausted = (tcnt_reg == CW'(N));
    assign shift_last     = (cnt_reg == CW'(N - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.start) state_next = CLEAR;
            CLEAR: state_next = SHIFT;
            SHIFT: if (shift_last) state_next = CHECK;
            CHECK: state_next = syn_zero ? DONE : TRAP;
            TRAP:  if (trapped || trap_exhausted) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; the trap-phase shift enable follows p_syndrome directly
    // so the shift stops in the same cycle the burst is seen.
    always_comb begin
        ready_c   = (state_reg == IDLE);
        done_c    = (state_reg == DONE);
        p_shift_c = 1'b0;
        case (state_reg)
            SHIFT:   p_shift_c = 1'b1;
            TRAP:    p_shift_c = !trapped && !trap_exhausted;
            default: p_shift_c = 1'b0;
        endcase
    end

    // Datapath: codeword latch, counters, result registers, clear pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_data_reg      <= '0;
            cnt_reg         <= '0;
            tcnt_reg        <= '0;
            p_clr_reg       <= 1'b0;
            err_det_reg     <= 1'b0;
            err_corr_reg    <= 1'b0;
            count_err_reg   <= 1'b0;
            burst_reg       <= '0;
            trap_shifts_reg <= '0;
        end else begin
            // Registered so the syndrome register sees a clean one-cycle
            // clear that coincides with the CLEAR state.
            p_clr_reg <= (state_next == CLEAR);
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        p_data_reg      <= bus.codeword_in;
                        err_det_reg     <= 1'b0;
                        err_corr_reg    <= 1'b0;
                        count_err_reg   <= 1'b0;
                        burst_reg       <= '0;
                        trap_shifts_reg <= '0;
                    end
                end
                CLEAR: begin
                    cnt_reg <= '0;
                end
                SHIFT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                CHECK: begin
                    // The syndrome register must have seen exactly N shifts.
                    count_err_reg <= (bus.p_count != CW'(N));
                    tcnt_reg      <= '0;
                    if (!syn_zero) begin
                        err_det_reg <= 1'b1;
                    end
                end
                TRAP: begin
                    if (trapped) begin
                        burst_reg       <= bus.p_syndrome[B-1:0];
                        err_corr_reg    <= 1'b1;
                        trap_shifts_reg <= tcnt_reg;
                    end else if (trap_exhausted) begin
                        err_corr_reg    <= 1'b0;
                        trap_shifts_reg <= CW'(N);
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready           = ready_c;
    assign bus.done            = done_c;
    assign bus.p_shift         = p_shift_c;
    assign bus.p_clr           = p_clr_reg;
    assign bus.p_data          = p_data_reg;
    assign bus.err_detected    = err_det_reg;
    assign bus.err_correctable = err_corr_reg;
    assign bus.count_err       = count_err_reg;
    assign bus.burst_pat       = burst_reg;
    assign bus.trap_shifts     = trap_shifts_reg;

endmodule

// File: tb/tb_fire_dec_ctrl.sv
// Directed bench for fire_dec_ctrl with a behavioural syndrome register
// (right-shifting, input into bit 8, feedback from bit 0 into bits 8 and 4,
// zero-fill once N bits have been consumed).
module tb_fire_dec_ctrl;

    localparam int N = 64;
    localparam int B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fire_dec_ctrl_if #(.N(N), .B(B)) bus ();

    fire_dec_ctrl #(.N(N), .B(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Syndrome register model
    logic [8:0]  m_syn;
    logic [8:0]  m_syn_next;
    logic [10:0] m_cnt;
    logic        m_din;
    logic        m_fb;
    logic        force_syn;
    logic        force_cnt;

    always_comb begin
        m_din = 1'b0;
        if (m_cnt < 11'd64) m_din = bus.p_data[6'd63 - m_cnt[5:0]];
        m_fb       = m_syn[0];
        m_syn_next = {m_din ^ m_fb, m_syn[8:6], m_syn[5] ^ m_fb, m_syn[4:1]};
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_syn <= '0;
            m_cnt <= '0;
        end else if (bus.p_clr) begin
            m_syn <= '0;
            m_cnt <= '0;
        end else if (bus.p_shift) begin
            m_syn <= m_syn_next;
            m_cnt <= m_cnt + 11'd1;
        end
    end

    assign bus.p_syndrome = force_syn ? 9'h1F0 : m_syn;
    assign bus.p_count    = force_cnt ? 11'd63 : m_cnt;

    int total = 0;
    int bad   = 0;

    int       done_at;
    int       shift_cnt;
    int       clr_cnt;
    int       clr_at;
    logic [8:0] syn_chk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one decode. Labels: value observed before edge k is "at k",
    // with edge 0 the one that samples start.
    task automatic decode(input logic [63:0] cw, input bit inject, input int limit);
        int e;
        done_at   = -1;
        shift_cnt = 0;
        clr_cnt   = 0;
        clr_at    = -1;
        syn_chk   = 'x;
        @(negedge clk);
        bus.codeword_in = cw;
        bus.start = 1'b1;
        @(posedge clk);
        e = 0;
        while (e < limit && done_at < 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (inject && (e == 20 || e == N + 3)) begin
                bus.start = 1'b1;
                bus.codeword_in = '1;
                chk("ready_busy", 64'(bus.ready), 64'd0);
            end
            if (bus.p_clr) begin
                clr_cnt++;
                clr_at = e + 1;
            end
            if (bus.p_shift) shift_cnt++;
            if (e + 1 == N + 2) syn_chk = bus.p_syndrome;
            if (bus.done) done_at = e + 1;
            @(posedge clk);
            e++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_pulse_end", 64'(bus.done), 64'd0);
        chk("ready_after", 64'(bus.ready), 64'd1);
        $display("decode cw=%h done_at=%0d shifts=%0d det=%0b corr=%0b burst=%h trap=%0d cerr=%0b",
                 cw, done_at, shift_cnt, bus.err_detected, bus.err_correctable,
                 bus.burst_pat, bus.trap_shifts, bus.count_err);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.codeword_in = '0;
        force_syn       = 1'b0;
        force_cnt       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_shift", 64'(bus.p_shift), 64'd0);
        chk("rst_clr", 64'(bus.p_clr), 64'd0);
        chk("rst_pdata", bus.p_data, 64'd0);
        chk("rst_det", 64'(bus.err_detected), 64'd0);
        chk("rst_trap", 64'(bus.trap_shifts), 64'd0);
        rst = 1'b0;

        // Clean codeword
        decode(64'h0, 1'b0, 200);
        chk("clean_clr_cnt", 64'(clr_cnt), 64'd1);
        chk("clean_clr_at", 64'(clr_at), 64'd1);
        chk("clean_shifts", 64'(shift_cnt), 64'd64);
        chk("clean_done_at", 64'(done_at), 64'd67);
        chk("clean_syn", 64'(syn_chk), 64'h0);
        chk("clean_det", 64'(bus.err_detected), 64'd0);
        chk("clean_corr", 64'(bus.err_correctable), 64'd0);
        chk("clean_cerr", 64'(bus.count_err), 64'd0);

        // Single-bit error, with start pulses during SHIFT and TRAP
        decode(64'h1, 1'b1, 200);
        chk("bit0_syn", 64'(syn_chk), 64'h100);
        chk("bit0_done_at", 64'(done_at), 64'd73);
        chk("bit0_shifts", 64'(shift_cnt), 64'd69);
        chk("bit0_clr_cnt", 64'(clr_cnt), 64'd1);
        chk("bit0_det", 64'(bus.err_detected), 64'd1);
        chk("bit0_corr", 64'(bus.err_correctable), 64'd1);
        chk("bit0_trap", 64'(bus.trap_shifts), 64'd5);
        chk("bit0_burst", 64'(bus.burst_pat), 64'h8);
        chk("bit0_pdata", bus.p_data, 64'h1);

        // Non-trappable syndrome: trap limit exhausted
        bus.codeword_in = '0;
        force_syn = 1'b1;
        decode(64'h0, 1'b0, 300);
        force_syn = 1'b0;
        chk("untrap_done_at", 64'(done_at), 64'd132);
        chk("untrap_shifts", 64'(shift_cnt), 64'd128);
        chk("untrap_det", 64'(bus.err_detected), 64'd1);
        chk("untrap_corr", 64'(bus.err_correctable), 64'd0);
        chk("untrap_trap", 64'(bus.trap_shifts), 64'd64);
        chk("untrap_burst", 64'(bus.burst_pat), 64'h0);

        // Shift count fault at CHECK
        force_cnt = 1'b1;
        decode(64'h0, 1'b0, 200);
        force_cnt = 1'b0;
        chk("cerr_flag", 64'(bus.count_err), 64'd1);
        chk("cerr_done_at", 64'(done_at), 64'd67);
        chk("cerr_det", 64'(bus.err_detected), 64'd0);

        // Reset in the middle of SHIFT
        @(negedge clk);
        bus.codeword_in = 64'h1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (31) @(posedge clk);
        @(negedge clk);
        chk("mid_shift_active", 64'(bus.p_shift), 64'd1);
        chk("mid_ready_low", 64'(bus.ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(bus.ready), 64'd1);
        chk("mid_rst_shift", 64'(bus.p_shift), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_pdata", bus.p_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Decode after the reset
        decode(64'h1, 1'b0, 200);
        chk("post_done_at", 64'(done_at), 64'd73);
        chk("post_shifts", 64'(shift_cnt), 64'd69);
        chk("post_trap", 64'(bus.trap_shifts), 64'd5);
        chk("post_burst", 64'(bus.burst_pat), 64'h8);
        chk("post_corr", 64'(bus.err_correctable), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fire_dec_ctrl.md
Name: fire_dec_ctrl

Overview:
Sequencer for the Fire-code syndrome shift register (R=9, generator feedback taps into bits 8 and 4).
- Latches a received codeword and clears the syndrome register, then drives exactly N shift pulses.
- Classifies the resulting syndrome.
- On a non-zero syndrome, runs error-trapping shifts (zero-fill) until a burst of at most B bits sits in the low syndrome bits, or until N trap shifts are exhausted.
- Sits between the receive buffer and the burst-correction stage.

Parameters:
N, 64, codeword length in bits; also the trap-shift limit.
R, 9, syndrome register width (fixed by the generator).
B, 4, maximum correctable burst length; 1 <= B < R.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin decode; sampled only in IDLE
codeword_in  in  N  received codeword; latched on the accepted start
ready  out  1  high in IDLE
done  out  1  one-cycle pulse, result valid
err_detected  out  1  final syndrome after N shifts was non-zero
err_correctable  out  1  burst trapped within the limit
burst_pat  out  B  trapped burst pattern, equal to syndrome[B-1:0]
trap_shifts  out  11  number of trap shifts performed
count_err  out  1  p_count != N in CHECK (sequencing fault)
p_clr  out  1  clear pulse to the syndrome register's rst input
p_shift  out  1  shift enable to the syndrome register
p_data  out  N  latched codeword to the syndrome register's data_in
p_count  in  11  syndrome register's shift count
p_syndrome  in  R  syndrome register contents

Behaviour:
- Reset (async): state=IDLE. All outputs are 0 except ready=1. p_data=0; internal counters=0.
- Clearing: the registered p_clr pulse is the only way the syndrome register is cleared.
- IDLE:
  - ready=1.
  - start=1 → latch codeword_in into p_data; clear err_detected, err_correctable, burst_pat, trap_shifts and count_err; go to CLEAR.
- CLEAR: p_clr=1 for exactly one cycle (registered) → SHIFT.
- SHIFT:
  - p_shift=1 every cycle; internal cnt increments.
  - After N cycles (cnt==N-1 on exit) → CHECK.
- CHECK:
  - No shift.
  - count_err <= (p_count != N).
  - p_syndrome==0 → DONE with err_detected=0 and err_correctable=0.
  - Otherwise err_detected <= 1; tcnt <= 0; go to TRAP.
- TRAP, evaluated every cycle against the current p_syndrome:
  - trapped = (p_syndrome[R-1:B]==0) && (p_syndrome!=0).
  - trapped → no shift; burst_pat <= p_syndrome[B-1:0]; err_correctable <= 1; trap_shifts <= tcnt; go to DONE.
  - Else if tcnt==N → no shift; err_correctable <= 0; trap_shifts <= N; go to DONE.
  - Else → p_shift=1; tcnt++.
  - p_shift in TRAP is combinational from p_syndrome and tcnt.
  - The syndrome register zero-fills automatically once count>=N; the block adds no data gating.
- DONE: done=1 for one cycle; result outputs hold until the next accepted start → IDLE.
- start outside IDLE is ignored; there is no queueing.
- Latency: start sampled at edge 0 gives CLEAR at 1, SHIFT at 2..N+1, CHECK at N+2.
  - Clean codeword: done at N+3.
  - Trapped: done at N+3+trap_shifts+1.
- Reset mid-operation: immediate return to IDLE. The syndrome register is reset by the same rst, so no stale state remains.
- Width rules:
  - cnt and tcnt are 11 bits, matching p_count.
  - Compares are unsigned.
  - p_count wraps are not expected; max count is 2N=128.

Decomposition:
- Shared package holds the state encoding (IDLE, CLEAR, SHIFT, CHECK, TRAP, DONE), R=9, and the count width of 11.
- One flat module: the FSM and counters are small.
- The syndrome register stays a separate sibling instance wired at the decoder top; it is not instantiated inside this block.

Test Plan:
- Reset then codeword_in=64'h0, start → p_clr pulse at cycle 1; 64 p_shift cycles; done at cycle 67; err_detected=0, count_err=0.
- codeword_in=64'h1 → syndrome 9'h100 at CHECK; err_detected=1; trap_shifts=5; burst_pat=4'b1000; err_correctable=1; done at cycle 67+6.
- Syndrome model driven with a non-trappable pattern (upper bits never zero) → 64 trap shifts; err_correctable=0; trap_shifts=64.
- start pulsed during SHIFT and TRAP → ignored; ready=0; results match a single decode.
- rst asserted at cycle 30 of SHIFT → ready=1, p_shift=0 and done=0 immediately; a new start decodes normally.
- Syndrome model forces p_count=63 at CHECK → count_err=1; decode still completes with done.
